operand_stage: RTL and testbench

Parametrised, registered operand-build stage between decode and ALU. Selects ALU operands `a`/`b` and a side operand `c` (store data or branch/jump target) for every instruction type, not only R-type. Presents them through a valid/ready handshake with a 2-entry skid buffer, so ALU back-pressure never drops or duplicates an instruction.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/skid_buffer.sv | 96 +++++++++
 rtl/operand_stage.sv | 113 +++++++++++
 tb/tb_operand_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: constants shared by the decode/execute pipeline stages.
//   - Instruction-type encodings (R_TYPE..N_TYPE, RSV_TYPE) for the
//     instr_type field. The field is 4 bits wide by default.
//   - LINK_OFFSET: the constant 4 used as the J-type "b" operand.
//     It is XLEN-wide, with XLEN=32 by default.
//   - REG_ADDR_W: width of a register-file address.
package riscv_pkg;

  localparam int DEF_XLEN   = 32;
  localparam int DEF_TYPE_W = 4;
  localparam int REG_ADDR_W = 5;

  localparam logic [DEF_TYPE_W-1:0] R_TYPE   = 4'd0;
  localparam logic [DEF_TYPE_W-1:0] I_TYPE   = 4'd1;
  localparam logic [DEF_TYPE_W-1:0] S_TYPE   = 4'd2;
  localparam logic [DEF_TYPE_W-1:0] B_TYPE   = 4'd3;
  localparam logic [DEF_TYPE_W-1:0] U_TYPE   = 4'd4;
  localparam logic [DEF_TYPE_W-1:0] J_TYPE   = 4'd5;
  localparam logic [DEF_TYPE_W-1:0] RSV_TYPE = 4'd6;
  localparam logic [DEF_TYPE_W-1:0] N_TYPE   = 4'd7;

  localparam logic [DEF_XLEN-1:0] LINK_OFFSET = 32'd4;

endpackage

// File: rtl/skid_buffer.sv
// skid_buffer: generic 2-entry valid/ready buffer with strict FIFO order.
// The MAIN entry drives out_data directly. The SKID entry absorbs one
// accept while the consumer stalls. in_ready is decoded from the state
// register only, so there is no combinational path from out_ready.
// Parameters: W - payload width.
// Ports:
//   clk, rst (sync, active-high), flush (sync kill of both entries)
//   in_valid/in_ready/in_data   - producer side
//   out_valid/out_ready/out_data - consumer side
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]   state, state_nxt;
  logic [W-1:0] main_q, main_nxt;
  logic [W-1:0] skid_q, skid_nxt;
  logic         in_acc, out_acc;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;

  // Next-state and entry-update logic for the EMPTY/ONE/FULL buffer
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state)
      EMPTY: begin
        if (in_acc) begin
          main_nxt  = in_data;
          state_nxt = ONE;
        end else begin
          state_nxt = EMPTY;
        end
      end
      ONE: begin
        if (in_acc && out_acc) begin
          // MAIN drains and refills on the same edge
          main_nxt  = in_data;
          state_nxt = ONE;
        end else if (in_acc) begin
          skid_nxt  = in_data;
          state_nxt = FULL;
        end else if (out_acc) begin
          state_nxt = EMPTY;
        end else begin
          state_nxt = ONE;
        end
      end
      FULL: begin
        if (out_acc) begin
          main_nxt  = skid_q;
          state_nxt = ONE;
        end else begin
          state_nxt = FULL;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // State and payload registers. A flush kills validity but keeps the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state  <= EMPTY;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

endmodule

// File: rtl/operand_stage.sv
// operand_stage: registered operand build between decode and the ALU.
// It selects a/b/c for every instruction type and flags reserved type 6
// as illegal. Results go through a 2-entry skid_buffer, so back-pressure
// from the ALU never drops or duplicates an instruction.
// Optional feature macro: OPERAND_FWD_EN. When it is defined, a writeback
// bypass replaces stale rs1/rs2 data before capture.
// Ports:
//   clk, rst (sync, active-high), flush
//   in_valid/in_ready, instr_type, u_pc_sel, rs1_data, rs2_data, pc, imm
//   out_valid/out_ready, a, b, c, out_illegal
//   [OPERAND_FWD_EN] rs1_addr, rs2_addr, wb_valid, wb_rd, wb_data
module operand_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int TYPE_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TYPE_W-1:0] instr_type,
  input  logic              u_pc_sel,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   imm,
`ifdef OPERAND_FWD_EN
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   a,
  output logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   c,
  output logic              out_illegal
);

  localparam int PW = 3 * XLEN + 1;

  localparam logic [TYPE_W-1:0] T_R   = TYPE_W'(R_TYPE);
  localparam logic [TYPE_W-1:0] T_I   = TYPE_W'(I_TYPE);
  localparam logic [TYPE_W-1:0] T_S   = TYPE_W'(S_TYPE);
  localparam logic [TYPE_W-1:0] T_B   = TYPE_W'(B_TYPE);
  localparam logic [TYPE_W-1:0] T_U   = TYPE_W'(U_TYPE);
  localparam logic [TYPE_W-1:0] T_J   = TYPE_W'(J_TYPE);
  localparam logic [TYPE_W-1:0] T_RSV = TYPE_W'(RSV_TYPE);
  localparam logic [TYPE_W-1:0] T_N   = TYPE_W'(N_TYPE);
  localparam logic [XLEN-1:0]   LINK  = XLEN'(LINK_OFFSET);

  logic [XLEN-1:0] rs1_eff, rs2_eff, target;
  logic [XLEN-1:0] a_nxt, b_nxt, c_nxt;
  logic            ill_nxt;
  logic [PW-1:0]   out_payload;

`ifdef OPERAND_FWD_EN
  // x0 is hard-wired to zero and is never forwarded
  assign rs1_eff = (wb_valid && (wb_rd == rs1_addr) && (wb_rd != 5'd0)) ? wb_data : rs1_data;
  assign rs2_eff = (wb_valid && (wb_rd == rs2_addr) && (wb_rd != 5'd0)) ? wb_data : rs2_data;
`else
  assign rs1_eff = rs1_data;
  assign rs2_eff = rs2_data;
`endif

  // Branch/jump target; the carry out of the sum is discarded
  assign target = pc + imm;

  // Operand mux by instruction type
  always_comb begin
    a_nxt   = '0;
    b_nxt   = '0;
    c_nxt   = '0;
    ill_nxt = 1'b0;
    case (instr_type)
      T_R: begin a_nxt = rs1_eff; b_nxt = rs2_eff; end
      T_I: begin a_nxt = rs1_eff; b_nxt = imm; end
      T_S: begin a_nxt = rs1_eff; b_nxt = imm; c_nxt = rs2_eff; end
      T_B: begin a_nxt = rs1_eff; b_nxt = rs2_eff; c_nxt = target; end
      T_U: begin
        if (u_pc_sel) begin
          a_nxt = pc;
        end else begin
          a_nxt = '0;
        end
        b_nxt = imm;
      end
      T_J:   begin a_nxt = pc; b_nxt = LINK; c_nxt = target; end
      T_RSV: begin ill_nxt = 1'b1; end
      T_N:   begin ill_nxt = 1'b0; end
      default: begin ill_nxt = 1'b0; end
    endcase
  end

  skid_buffer #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({ill_nxt, a_nxt, b_nxt, c_nxt}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign {out_illegal, a, b, c} = out_payload;

endmodule

// File: tb/tb_operand_stage.sv
module tb_operand_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, u_pc_sel;
  logic [3:0]  instr_type;
  logic [31:0] rs1_data, rs2_data, pc, imm;
  logic        out_valid, out_ready, out_illegal;
  logic [31:0] a, b, c;
`ifdef OPERAND_FWD_EN
  logic [4:0]  rs1_addr, rs2_addr, wb_rd;
  logic        wb_valid;
  logic [31:0] wb_data;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  operand_stage #(.XLEN(32), .TYPE_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr_type(instr_type), .u_pc_sel(u_pc_sel),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .pc(pc), .imm(imm),
`ifdef OPERAND_FWD_EN
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .c(c), .out_illegal(out_illegal)
  );

  // Present one instruction at the falling edge (stimulus only, no checking)
  task automatic present(input logic [3:0] t, input logic sel,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] p, input logic [31:0] im);
    @(negedge clk);
    in_valid = 1'b1; instr_type = t; u_pc_sel = sel;
    rs1_data = r1; rs2_data = r2; pc = p; imm = im;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr_type = R_TYPE; u_pc_sel = 1'b0;
    rs1_data = 32'h0; rs2_data = 32'h0; pc = 32'h0; imm = 32'h0;
`ifdef OPERAND_FWD_EN
    rs1_addr = 5'd0; rs2_addr = 5'd0; wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
`endif
    tick(); tick();
    vectors++;
    if ({out_valid, in_ready, out_illegal, a, b, c} !== {3'b010, 96'h0}) begin
      errors++;
      $display("FAIL reset: got v=%b rdy=%b ill=%b a=%h b=%h c=%h, want v=0 rdy=1 ill=0 abc=0",
               out_valid, in_ready, out_illegal, a, b, c);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_rtype();
    out_ready = 1'b1;
    present(R_TYPE, 1'b0, 32'h10, 32'h20, 32'h500, 32'h7);
    tick();
    vectors++;
    if ({out_valid, out_illegal, a, b, c} !== {2'b10, 32'h10, 32'h20, 32'h0}) begin
      errors++;
      $display("FAIL rtype: got v=%b ill=%b a=%h b=%h c=%h, want v=1 a=10 b=20 c=0",
               out_valid, out_illegal, a, b, c);
    end
    @(negedge clk); in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rtype_drain: got out_valid=%b, want 0", out_valid);
    end
  endtask

  // Streaming at one instruction per cycle across the remaining types
  task automatic test_types();
    logic [3:0]  t_tab  [6] = '{I_TYPE, S_TYPE, B_TYPE, U_TYPE, U_TYPE, N_TYPE};
    logic        s_tab  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [95:0] e_tab  [6] = '{
      {32'h11,   32'h24, 32'h0},
      {32'h11,   32'h24, 32'h22},
      {32'h11,   32'h22, 32'h1024},
      {32'h1000, 32'h24, 32'h0},
      {32'h0,    32'h24, 32'h0},
      {32'h0,    32'h0,  32'h0}};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      present(t_tab[i], s_tab[i], 32'h11, 32'h22, 32'h1000, 32'h24);
      tick();
      vectors++;
      if ({out_valid, out_illegal, a, b, c} !== {2'b10, e_tab[i]}) begin
        errors++;
        $display("FAIL type_%0d: got v=%b ill=%b abc=%h, want v=1 ill=0 abc=%h",
                 i, out_valid, out_illegal, {a, b, c}, e_tab[i]);
      end
    end
    @(negedge clk); in_valid = 1'b0;
    tick();
  endtask

  task automatic test_jwrap();
    out_ready = 1'b1;
    present(J_TYPE, 1'b0, 32'h5, 32'h6, 32'hFFFF_FFF8, 32'h10);
    tick();
    vectors++;
    if ({out_valid, a, b, c} !== {1'b1, 32'hFFFF_FFF8, 32'h4, 32'h8}) begin
      errors++;
      $display("FAIL jwrap: got v=%b a=%h b=%h c=%h, want v=1 a=fffffff8 b=4 c=8",
               out_valid, a, b, c);
    end
    @(negedge clk); in_valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    present(RSV_TYPE, 1'b1, 32'h33, 32'h44, 32'h55, 32'h66);
    tick();
    vectors++;
    if ({out_valid, out_illegal, a, b, c} !== {2'b11, 96'h0}) begin
      errors++;
      $display("FAIL illegal: got v=%b ill=%b abc=%h, want v=1 ill=1 abc=0",
               out_valid, out_illegal, {a, b, c});
    end
    present(R_TYPE, 1'b0, 32'h1, 32'h2, 32'h0, 32'h0);
    tick();
    vectors++;
    if ({out_valid, out_illegal, a, b} !== {2'b10, 32'h1, 32'h2}) begin
      errors++;
      $display("FAIL illegal_clear: got v=%b ill=%b a=%h b=%h, want v=1 ill=0 a=1 b=2",
               out_valid, out_illegal, a, b);
    end
    @(negedge clk); in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    present(R_TYPE, 1'b0, 32'h101, 32'h0, 32'h0, 32'h0);
    tick();
    vectors++;
    if ({out_valid, in_ready, a} !== {2'b11, 32'h101}) begin
      errors++;
      $display("FAIL b2b_first: got v=%b rdy=%b a=%h, want v=1 rdy=1 a=101", out_valid, in_ready, a);
    end
    present(R_TYPE, 1'b0, 32'h102, 32'h0, 32'h0, 32'h0);
    tick();
    vectors++;
    if ({out_valid, in_ready, a} !== {2'b10, 32'h101}) begin
      errors++;
      $display("FAIL b2b_full: got v=%b rdy=%b a=%h, want v=1 rdy=0 a=101", out_valid, in_ready, a);
    end
    // Third instruction is held by decode while the stage is full
    present(R_TYPE, 1'b0, 32'h103, 32'h0, 32'h0, 32'h0);
    tick();
    vectors++;
    if ({out_valid, in_ready, out_illegal, a, b, c} !== {3'b100, 32'h101, 64'h0}) begin
      errors++;
      $display("FAIL b2b_stall: got v=%b rdy=%b a=%h, want v=1 rdy=0 a=101 stable", out_valid, in_ready, a);
    end
    @(negedge clk); out_ready = 1'b1;
    tick();
    vectors++;
    if ({out_valid, in_ready, a} !== {2'b11, 32'h102}) begin
      errors++;
      $display("FAIL b2b_second: got v=%b rdy=%b a=%h, want v=1 rdy=1 a=102", out_valid, in_ready, a);
    end
    tick();
    vectors++;
    if ({out_valid, a} !== {1'b1, 32'h103}) begin
      errors++;
      $display("FAIL b2b_third: got v=%b a=%h, want v=1 a=103", out_valid, a);
    end
    @(negedge clk); in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_nodup: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    present(R_TYPE, 1'b0, 32'h201, 32'h0, 32'h0, 32'h0);
    tick();
    present(R_TYPE, 1'b0, 32'h202, 32'h0, 32'h0, 32'h0);
    tick();
    present(R_TYPE, 1'b0, 32'hDEAD, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    tick();
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush: got v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
    end
    @(negedge clk); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: got out_valid=%b a=%h, want out_valid=0", out_valid, a);
    end
    present(I_TYPE, 1'b0, 32'h301, 32'h0, 32'h0, 32'h9);
    tick();
    vectors++;
    if ({out_valid, a, b} !== {1'b1, 32'h301, 32'h9}) begin
      errors++;
      $display("FAIL flush_resume: got v=%b a=%h b=%h, want v=1 a=301 b=9", out_valid, a, b);
    end
    @(negedge clk); in_valid = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b0;
    present(S_TYPE, 1'b0, 32'h401, 32'h402, 32'h0, 32'h8);
    tick();
    present(S_TYPE, 1'b0, 32'h403, 32'h404, 32'h0, 32'h8);
    rst = 1'b1;
    tick();
    vectors++;
    if ({out_valid, in_ready, a, b, c} !== {2'b01, 96'h0}) begin
      errors++;
      $display("FAIL rst_mid: got v=%b rdy=%b abc=%h, want v=0 rdy=1 abc=0",
               out_valid, in_ready, {a, b, c});
    end
    @(negedge clk); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
  endtask

`ifdef OPERAND_FWD_EN
  task automatic test_fwd();
    out_ready = 1'b1;
    present(R_TYPE, 1'b0, 32'h1, 32'h2, 32'h0, 32'h0);
    rs1_addr = 5'd5; rs2_addr = 5'd6; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hAB;
    tick();
    vectors++;
    if ({a, b} !== {32'hAB, 32'h2}) begin
      errors++;
      $display("FAIL fwd_hit: got a=%h b=%h, want a=ab b=2", a, b);
    end
    @(negedge clk); wb_rd = 5'd0; rs1_addr = 5'd0;
    tick();
    vectors++;
    if (a !== 32'h1) begin
      errors++;
      $display("FAIL fwd_x0: got a=%h, want a=1", a);
    end
    @(negedge clk); in_valid = 1'b0; wb_valid = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_rtype();
    test_types();
    test_jwrap();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_rst_mid();
`ifdef OPERAND_FWD_EN
    test_fwd();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
